uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//   Transmit side of the UART link: 8N1 serializer (optional parity), fed by a small byte FIFO.
//   Bytes are queued with a one-cycle strobe and sent LSB first on o_TX_Serial, back to back, with no idle gap.
//   Pairs with the UART_RX receiver: same CLKS_PER_BIT (217 = 25 MHz / 115200 baud).
// PARAMETERS
//   CLKS_PER_BIT  217  clock cycles per serial bit; legal range >= 2
//   FIFO_DEPTH    4    queued bytes; power of two, >= 2
//   PARITY_EN     0    1 = insert a parity bit between D7 and the stop bit
//   PARITY_ODD    0    parity sense when PARITY_EN=1: 0 = even, 1 = odd
// PORTS
//   i_Clock       in   1   system clock; all state on the rising edge
//   i_Rst_n       in   1   asynchronous, active-low reset
//   i_TX_DV       in   1   write strobe; i_TX_Byte is queued when i_TX_DV=1 and o_TX_Ready=1
//   i_TX_Byte     in   8   byte to queue
//   o_TX_Ready    out  1   FIFO not full (count < FIFO_DEPTH); driven from the registered count
//   o_TX_Serial   out  1   serial line; idles high
//   o_TX_Active   out  1   high from the first start-bit cycle to the last stop-bit cycle
//   o_TX_Done     out  1   one-cycle pulse on the last cycle of each stop bit
//   o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  number of queued bytes, not counting the byte being sent
// BEHAVIOUR
//   Reset (async assert, sync deassert by the user): o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0,
//     o_FIFO_Count=0, o_TX_Ready=1, FSM=IDLE. FIFO contents are discarded.
//   Reset mid-frame: the line goes high immediately and the frame is abandoned. No o_TX_Done pulse.
//   FIFO: write and read pointers wrap modulo FIFO_DEPTH.
//     A write while full is dropped, even if a pop happens in the same cycle. Nothing else changes.
//     A write and a pop in the same cycle leave the count unchanged.
//   FSM states: IDLE, START, DATA, PARITY, STOP.
//     IDLE: serial=1. If the FIFO is non-empty: pop into shift reg, clear bit counter, go to START.
//     START: serial=0 for CLKS_PER_BIT cycles, then go to DATA.
//     DATA: serial=shift[0] for CLKS_PER_BIT cycles per bit, shifting right; 8 bits (index 0..7).
//       After bit 7: go to PARITY if PARITY_EN=1, otherwise go to STOP.
//     PARITY: serial = (^byte) ^ PARITY_ODD for CLKS_PER_BIT cycles, then go to STOP.
//     STOP: serial=1 for CLKS_PER_BIT cycles. On the last cycle, o_TX_Done=1, then:
//       - if the FIFO is non-empty: pop and go straight to START (no extra idle cycle);
//       - otherwise: go to IDLE.
//   Baud counter: counts 0..CLKS_PER_BIT-1, resets on every state/bit change, never free-runs.
//   Latency: a byte written at edge N into an empty FIFO in IDLE is popped at edge N+1.
//     o_TX_Serial goes low from edge N+1.
//   Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity). Every bit is exact; no jitter.
//   o_TX_Serial is registered, so the line is glitch-free.
//   i_TX_Byte is sampled only on an accepted write; later changes do not affect a queued byte.
// TESTING
//   1. CLKS_PER_BIT=217; write 0x37 once
//      -> line carries 0,1,1,1,0,1,1,0,0,1, each bit 217 cycles;
//      -> exactly one o_TX_Done pulse; looped into UART_RX, o_RX_Byte=0x37.
//   2. Write 0xA5,0x00,0xFF,0x3C,0x81 on 5 consecutive cycles
//      -> o_FIFO_Count reaches 4 and o_TX_Ready=0;
//      -> a 6th write is dropped;
//      -> 5 frames back to back in 5*2170 cycles, no high gap beyond the stop bits.
//   3. PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit=1, 11-bit frame.
//      Same byte with PARITY_ODD=1 -> parity bit=0.
//   4. Assert i_Rst_n=0 during DATA bit 3
//      -> o_TX_Serial=1 before the next clock edge; o_FIFO_Count=0; o_TX_Active=0; no o_TX_Done pulse.
//   5. FIFO full, write and pop on the same cycle (end of stop bit)
//      -> write dropped, count goes 4->3, o_TX_Ready=1 on the next cycle.
//   6. CLKS_PER_BIT=4, write 0x55
//      -> serial low exactly 1 cycle after the write edge;
//      -> alternating bits every 4 cycles; frame ends after 40 cycles.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small byte FIFO feeding an 8N1 serializer with optional parity.
// Frames are sent back to back; the line output is registered so it never glitches.
`timescale 1ns / 1ps

module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_n,
  input  logic                        i_TX_DV,
  input  logic [7:0]                  i_TX_Byte,
  output logic                        o_TX_Ready,
  output logic                        o_TX_Serial,
  output logic                        o_TX_Active,
  output logic                        o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0]  Full     = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              serial_q, serial_d;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              wr_en;
  logic              pop;
  logic              baud_last;
  logic              fifo_nonempty;

  // Writes are gated by the registered count, so a write while full is dropped even if a pop
  // frees a slot in the same cycle.
  assign wr_en         = i_TX_DV && (count_q < Full);
  assign baud_last     = (baud_q == BaudLast);
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = StStart;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (baud_last) begin
          state_d = StData;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = PARITY_EN ? StParity : StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StParity: begin
        if (baud_last) begin
          state_d = StStop;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
      end
    endcase

    if (pop) begin
      shift_d  = fifo_mem[rd_ptr_q];
      parity_d = (^fifo_mem[rd_ptr_q]) ^ PARITY_ODD;
      bit_d    = '0;
    end
  end

  // Line level follows the state being entered, so it changes on the same edge as the state.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = shift_d[0];
      StParity: serial_d = parity_d;
      default:  serial_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (wr_en && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= i_TX_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_TX_Ready   = (count_q < Full);
  assign o_TX_Serial  = serial_q;
  assign o_TX_Active  = (state_q != StIdle);
  assign o_TX_Done    = (state_q == StStop) && baud_last;
  assign o_FIFO_Count = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three parameterisations share one stimulus stream and are checked
// every cycle against a frame-level model (byte queue plus position within the current frame).
`timescale 1ns / 1ps

module tb_uart_tx_buffered;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       dv      = 1'b0;
  logic [7:0] tx_byte = 8'h00;

  logic       ready  [N];
  logic       serial [N];
  logic       active [N];
  logic       done   [N];
  logic [2:0] count  [N];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) u_dut_a (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
    .o_TX_Ready(ready[0]), .o_TX_Serial(serial[0]), .o_TX_Active(active[0]),
    .o_TX_Done(done[0]), .o_FIFO_Count(count[0])
  );

  uart_tx_buffered #(
    .CLKS_PER_BIT(3), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) u_dut_b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
    .o_TX_Ready(ready[1]), .o_TX_Serial(serial[1]), .o_TX_Active(active[1]),
    .o_TX_Done(done[1]), .o_FIFO_Count(count[1])
  );

  uart_tx_buffered #(
    .CLKS_PER_BIT(5), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)
  ) u_dut_c (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
    .o_TX_Ready(ready[2]), .o_TX_Serial(serial[2]), .o_TX_Active(active[2]),
    .o_TX_Done(done[2]), .o_FIFO_Count(count[2])
  );

  // Reference model: queued bytes plus the frame on the line and the cycle position within it.
  int          cpb [N];
  bit          pe  [N];
  bit          po  [N];
  logic [7:0]  mq  [N][$];
  bit          m_active [N];
  int          m_pos    [N];
  int          m_len    [N];
  logic [10:0] m_bits   [N];

  task automatic start_frame(input int i, input logic [7:0] b);
    logic [10:0] f;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (pe[i]) f[9] = (^b) ^ po[i];
    m_bits[i]   = f;
    m_len[i]    = (pe[i] ? 11 : 10) * cpb[i];
    m_pos[i]    = 0;
    m_active[i] = 1'b1;
  endtask

  function automatic bit busy();
    bit b = 1'b0;
    for (int i = 0; i < N; i++) if (m_active[i] || mq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input int i);
    logic [6:0] obs;
    logic [6:0] exp;
    logic       exp_ser;
    logic       exp_done;
    exp_ser  = m_active[i] ? m_bits[i][m_pos[i] / cpb[i]] : 1'b1;
    exp_done = m_active[i] && (m_pos[i] == m_len[i] - 1);
    obs = {serial[i], active[i], done[i], ready[i], count[i]};
    exp = {exp_ser, m_active[i], exp_done, (mq[i].size() < DEPTH), 3'(mq[i].size())};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL cycle dut%0d t=%0t {ser,act,done,rdy,cnt}: observed %b expected %b",
             i, $time, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then check every instance.
  task automatic step(input logic dv_v, input logic [7:0] b_v);
    dv      = dv_v;
    tx_byte = b_v;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      int         pre;
      bit         acc;
      bit         last;
      logic [7:0] b;
      pre  = mq[i].size();
      acc  = dv_v && (pre < DEPTH);
      last = m_active[i] && (m_pos[i] == m_len[i] - 1);
      if (pre > 0 && (!m_active[i] || last)) begin
        b = mq[i].pop_front();
        start_frame(i, b);
      end else if (last) begin
        m_active[i] = 1'b0;
      end else if (m_active[i]) begin
        m_pos[i]++;
      end
      if (acc) mq[i].push_back(b_v);
    end
    #1;
    for (int i = 0; i < N; i++) check_cycle(i);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step(1'b0, 8'h00);
      n++;
    end
    vectors++;
    assert (!busy()) else begin
      miscompares++;
      $error("FAIL drain: still busy after %0d cycles, expected idle", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cpb = '{4, 3, 5};
    pe  = '{1'b0, 1'b1, 1'b1};
    po  = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0;
      m_pos[i]    = 0;
      m_len[i]    = 0;
      m_bits[i]   = 11'h7FF;
    end

    // Reset values
    #2 rst_n = 1'b0;
    #10;
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("rst_serial%0d", i), 8'(serial[i]), 8'd1);
      check_val($sformatf("rst_active%0d", i), 8'(active[i]), 8'd0);
      check_val($sformatf("rst_done%0d", i),   8'(done[i]),   8'd0);
      check_val($sformatf("rst_count%0d", i),  8'(count[i]),  8'd0);
      check_val($sformatf("rst_ready%0d", i),  8'(ready[i]),  8'd1);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00);

    // Single byte, then 0x55 for the alternating pattern
    step(1'b1, 8'h37);
    check_val("lat_37", 8'(serial[0]), 8'd1);
    step(1'b0, 8'h00);
    check_val("start_37", 8'(serial[0]), 8'd0);
    drain(400);
    step(1'b1, 8'h55);
    drain(400);

    // Burst of five, sixth dropped, then keep writing through the full+pop boundary
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h3C);
    step(1'b1, 8'h81);
    check_val("burst_count", 8'(count[0]), 8'd4);
    check_val("burst_ready", 8'(ready[0]), 8'd0);
    step(1'b1, 8'h99);
    check_val("drop_count", 8'(count[0]), 8'd4);
    for (int k = 0; k < 60; k++) step(1'b1, 8'($urandom));
    drain(400);

    // Parity byte
    step(1'b1, 8'h07);
    drain(400);

    // Reset during data bit 3 of a frame with bytes still queued
    step(1'b1, 8'hC3);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    check_val("pre_rst_count", 8'(count[0]), 8'd2);
    n = 0;
    while (!(m_active[0] && (m_pos[0] / cpb[0]) == 4) && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    vectors++;
    assert (m_active[0] && (m_pos[0] / cpb[0]) == 4) else begin
      miscompares++;
      $error("FAIL reach_bit3: gave up after %0d cycles, expected data bit 3", n);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("midrst_serial%0d", i), 8'(serial[i]), 8'd1);
      check_val($sformatf("midrst_active%0d", i), 8'(active[i]), 8'd0);
      check_val($sformatf("midrst_done%0d", i),   8'(done[i]),   8'd0);
      check_val($sformatf("midrst_count%0d", i),  8'(count[i]),  8'd0);
      mq[i].delete();
      m_active[i] = 1'b0;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00);

    // Random traffic: dense (FIFO often full) then sparse (frequent idle starts)
    for (int k = 0; k < 3000; k++) step(($urandom_range(0, 2) == 0), 8'($urandom));
    for (int k = 0; k < 2000; k++) step(($urandom_range(0, 39) == 0), 8'($urandom));
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
